// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline write-back and long-latency results onto one RF write port; pipe is zero latency, lu results write at the earliest one cycle after acceptance.
// Backpressure: lu stream via lu_ready (one-entry buffer); the pipe cannot be stalled here, so starve_stall asks it to freeze.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  input  logic        issue_en,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  dec_a_reg,
  input  logic [4:0]  dec_b_reg,
  input  logic [4:0]  dec_d_reg,
  output logic        hazard_stall,
  output logic        starve_stall,
  output logic        write_back_en,
  output logic [4:0]  write_back_reg,
  output logic [31:0] write_back
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        buf_valid;
  logic [4:0]  buf_reg;
  logic [31:0] buf_data;
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic [31:0] busy_rd;
  logic [3:0]  starve_cnt;
  logic [3:0]  cnt_next;
  logic        starve_q;
  logic        lu_accept;
  logic        buf_sel;

  assign lu_ready  = !buf_valid;
  assign lu_accept = lu_valid && lu_ready;
  // A result still buffered when reset hits is discarded, so it must never reach the port.
  assign buf_sel   = buf_valid && !pipe_valid && !rst;

  always_comb begin
    write_back_en  = 1'b0;
    write_back_reg = 5'd0;
    write_back     = 32'd0;
    if (pipe_valid) begin
      write_back_en  = (pipe_reg != 5'd0);
      write_back_reg = pipe_reg;
      write_back     = pipe_data;
    end else if (buf_sel) begin
      write_back_en  = (buf_reg != 5'd0);
      write_back_reg = buf_reg;
      write_back     = buf_data;
    end
  end

  // Clear first so a same-edge issue to the draining register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (buf_sel) busy_next[buf_reg] = 1'b0;
    if (issue_en && issue_reg != 5'd0) busy_next[issue_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = 4'd0;
    if (buf_valid && pipe_valid) begin
      cnt_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  assign busy_rd      = {busy[31:1], 1'b0};
  assign hazard_stall = busy_rd[dec_a_reg] | busy_rd[dec_b_reg] | busy_rd[dec_d_reg];
  assign starve_stall = starve_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      buf_reg    <= 5'd0;
      buf_data   <= 32'd0;
      busy       <= 32'd0;
      starve_cnt <= 4'd0;
      starve_q   <= 1'b0;
    end else begin
      if (lu_accept) begin
        buf_valid <= 1'b1;
        buf_reg   <= lu_reg;
        buf_data  <= lu_data;
      end else if (buf_sel) begin
        buf_valid <= 1'b0;
      end
      busy       <= busy_next;
      starve_cnt <= cnt_next;
      starve_q   <= (cnt_next == LIMIT);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue, a negedge monitor matches them.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic [4:0]  dec_a_reg;
  logic [4:0]  dec_b_reg;
  logic [4:0]  dec_d_reg;
  logic        hazard_stall;
  logic        starve_stall;
  logic        write_back_en;
  logic [4:0]  write_back_reg;
  logic [31:0] write_back;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .dec_a_reg(dec_a_reg), .dec_b_reg(dec_b_reg), .dec_d_reg(dec_d_reg),
    .hazard_stall(hazard_stall), .starve_stall(starve_stall),
    .write_back_en(write_back_en), .write_back_reg(write_back_reg), .write_back(write_back)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int          cyc;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (starve_stall === 1'b1) chk("pipe_quiet_during_starve", 32'(pipe_valid), 32'd0);
    if (write_back_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: reg %0d data 0x%0h with none expected (cycle %0d)",
                 write_back_reg, write_back, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_reg", 32'(write_back_reg), 32'(mon_e.r));
        chk("wb_data", write_back, mon_e.d);
        chk("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: reg %0d data 0x%0h expected in cycle %0d, none by cycle %0d",
               mon_e.r, mon_e.d, mon_e.cyc, cyc);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    pipe_valid = 1'b0; pipe_reg = 5'd0; pipe_data = 32'd0;
    lu_valid = 1'b0; lu_reg = 5'd0; lu_data = 32'd0;
    issue_en = 1'b0; issue_reg = 5'd0;
    dec_a_reg = 5'd0; dec_b_reg = 5'd0; dec_d_reg = 5'd0;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_t e;
    e.r = r;
    e.d = d;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic hz(input string name, input logic [4:0] a, input logic [4:0] b,
                    input logic [4:0] d, input logic exp);
    dec_a_reg = a;
    dec_b_reg = b;
    dec_d_reg = d;
    #1;
    chk(name, 32'(hazard_stall), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    smp();
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    chk("rst_starve", 32'(starve_stall), 32'd0);
    chk("rst_wb_en", 32'(write_back_en), 32'd0);
    chk("rst_wb_reg", 32'(write_back_reg), 32'd0);
    chk("rst_wb_data", write_back, 32'd0);

    // Zero-latency pipe write
    nxt(); idle();
    pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF);
    smp();
    chk("pipe_same_cycle_en", 32'(write_back_en), 32'd1);

    // Issue reg 8, accept lu result, drain next cycle
    nxt(); idle();
    issue_en = 1'b1; issue_reg = 5'd8;
    smp();
    hz("no_issue_bypass", 5'd8, 5'd0, 5'd0, 1'b0);
    nxt(); idle();
    lu_valid = 1'b1; lu_reg = 5'd8; lu_data = 32'h1234;
    smp();
    chk("lu_ready_empty", 32'(lu_ready), 32'd1);
    hz("busy8_after_issue", 5'd8, 5'd0, 5'd0, 1'b1);
    nxt(); idle();
    push(5'd8, 32'h1234);
    smp();
    chk("lu_ready_full", 32'(lu_ready), 32'd0);
    hz("busy8_until_drain", 5'd8, 5'd0, 5'd0, 1'b1);
    nxt(); idle();
    smp();
    hz("busy8_cleared", 5'd8, 5'd0, 5'd0, 1'b0);
    chk("lu_ready_after_drain", 32'(lu_ready), 32'd1);

    // Starvation: buffer holds reg 3 under four pipe writes
    nxt(); idle();
    lu_valid = 1'b1; lu_reg = 5'd3; lu_data = 32'h33333333;
    smp();
    for (int k = 0; k < 4; k++) begin
      nxt(); idle();
      pipe_valid = 1'b1; pipe_reg = 5'(20 + k); pipe_data = 32'hA0000000 + 32'(k);
      push(5'(20 + k), 32'hA0000000 + 32'(k));
      smp();
      chk("starve_lu_ready_low", 32'(lu_ready), 32'd0);
      chk("starve_not_yet", 32'(starve_stall), 32'd0);
    end
    nxt(); idle();
    push(5'd3, 32'h33333333);
    smp();
    chk("starve_raised", 32'(starve_stall), 32'd1);
    chk("starve_lu_ready_still_low", 32'(lu_ready), 32'd0);
    nxt(); idle();
    smp();
    chk("starve_fell", 32'(starve_stall), 32'd0);
    chk("starve_lu_ready_back", 32'(lu_ready), 32'd1);

    // Register 0: never written, never busy
    nxt(); idle();
    issue_en = 1'b1; issue_reg = 5'd0;
    pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hFFFF;
    smp();
    chk("pipe_reg0_no_en", 32'(write_back_en), 32'd0);
    nxt(); idle();
    lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'hAA;
    smp();
    hz("reg0_issue_ignored", 5'd0, 5'd0, 5'd0, 1'b0);
    nxt(); idle();
    smp();
    chk("reg0_buf_held", 32'(lu_ready), 32'd0);
    chk("reg0_drain_no_en", 32'(write_back_en), 32'd0);
    nxt(); idle();
    smp();
    chk("reg0_drained", 32'(lu_ready), 32'd1);

    // Same-edge drain and issue of reg 9: set wins
    nxt(); idle();
    issue_en = 1'b1; issue_reg = 5'd9;
    smp();
    nxt(); idle();
    lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h99;
    smp();
    nxt(); idle();
    issue_en = 1'b1; issue_reg = 5'd9;
    push(5'd9, 32'h99);
    smp();
    nxt(); idle();
    lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h999;
    smp();
    hz("set_wins_busy9", 5'd9, 5'd0, 5'd0, 1'b1);
    // Drain 9 while issuing 10
    nxt(); idle();
    issue_en = 1'b1; issue_reg = 5'd10;
    push(5'd9, 32'h999);
    smp();
    nxt(); idle();
    smp();
    hz("drain_clears_busy9", 5'd9, 5'd0, 5'd0, 1'b0);
    hz("issue_sets_busy10_d", 5'd0, 5'd0, 5'd10, 1'b1);
    hz("issue_sets_busy10_b", 5'd0, 5'd10, 5'd0, 1'b1);

    // Reset one cycle after accepting reg 12
    nxt(); idle();
    issue_en = 1'b1; issue_reg = 5'd12;
    smp();
    nxt(); idle();
    lu_valid = 1'b1; lu_reg = 5'd12; lu_data = 32'hC0C0C0C0;
    smp();
    nxt(); idle();
    rst = 1'b1;
    smp();
    chk("rst_cycle_no_write", 32'(write_back_en), 32'd0);
    nxt(); idle();
    rst = 1'b0;
    smp();
    chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("post_rst_starve", 32'(starve_stall), 32'd0);
    hz("rst_clears_busy12", 5'd12, 5'd0, 5'd0, 1'b0);
    hz("rst_clears_busy10", 5'd0, 5'd0, 5'd10, 1'b0);
    repeat (4) begin
      nxt(); idle();
      smp();
    end
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
